// File: rtl/tm_control.sv
// Turing-machine finite-state control: table lookup on each tape read, drives write/move to the tape.
// Latency: new_sym/direction/cur_state/steps register on the sym_valid edge, valid the next cycle, held until the next read.
// Backpressure: none; the tape paces the machine through sym_valid, and the tape is held in reset outside RUN/DRAIN.
// Optional: define STEP_LIMIT_EN to stop a run once steps reaches MAX_STEPS (timeout=1).
module tm_control #(
  parameter int STATE_W     = 4,
  parameter int SYM_W       = 3,
  parameter int START_STATE = 1,
  parameter int HALT_STATE  = 0,
  parameter int MAX_STEPS   = 1000000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       tbl_we,
  input  logic [STATE_W+SYM_W-1:0]   tbl_addr,
  input  logic [STATE_W+SYM_W:0]     tbl_data,
  input  logic [SYM_W-1:0]           sym,
  input  logic                       sym_valid,
  output logic [SYM_W-1:0]           new_sym,
  output logic                       direction,
  output logic                       tape_reset,
  output logic [STATE_W-1:0]         cur_state,
  output logic                       running,
  output logic                       halted,
  output logic [31:0]                steps,
  output logic                       timeout
);

  localparam int ADDR_W = STATE_W + SYM_W;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [STATE_W-1:0] START_S    = STATE_W'(START_STATE);
  localparam logic [STATE_W-1:0] HALT_S     = STATE_W'(HALT_STATE);
  localparam logic [31:0]        STEP_LIMIT = 32'(MAX_STEPS);

`ifdef STEP_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  // One transition-table entry; dir=1 moves the head right.
  typedef struct packed {
    logic [STATE_W-1:0] next_state;
    logic [SYM_W-1:0]   new_sym;
    logic               dir;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } fsm_t;

  fsm_t        fsm;
  logic [1:0]  drain_cnt;
  entry_t      tbl [DEPTH];
  entry_t      entry;
  logic        tbl_open;
  logic [31:0] steps_inc;
  logic        to_halt;
  logic        limit_hit;

  // The table may only change while the tape is parked, so a run never sees a half-updated program.
  assign tbl_open  = (fsm == S_IDLE) || (fsm == S_HALTED);
  assign entry     = tbl[{cur_state, sym}];
  assign steps_inc = steps + 32'd1;
  assign to_halt   = (entry.next_state == HALT_S);
  // Only a non-halting step can trip the limit; a halting step ends the run normally.
  assign limit_hit = LIMIT_EN && !to_halt && (steps_inc == STEP_LIMIT);

  // Table storage: not reset, so a program survives a mid-run reset.
  always_ff @(posedge clock) begin
    if (tbl_we && tbl_open) begin
      tbl[tbl_addr] <= entry_t'(tbl_data);
    end
  end

  // Machine FSM with registered tape-facing and status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fsm        <= S_IDLE;
      drain_cnt  <= 2'd0;
      cur_state  <= START_S;
      new_sym    <= '0;
      direction  <= 1'b0;
      steps      <= 32'd0;
      timeout    <= 1'b0;
      tape_reset <= 1'b1;
      running    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE, S_HALTED: begin
          // A read strobe coincident with start is not consumed: the tape has not been released yet.
          if (start) begin
            fsm        <= S_RUN;
            cur_state  <= START_S;
            steps      <= 32'd0;
            timeout    <= 1'b0;
            tape_reset <= 1'b0;
            running    <= 1'b1;
            halted     <= 1'b0;
          end
        end
        S_RUN: begin
          if (sym_valid) begin
            new_sym   <= entry.new_sym;
            direction <= entry.dir;
            cur_state <= entry.next_state;
            steps     <= steps_inc;
            if (to_halt || limit_hit) begin
              fsm       <= S_DRAIN;
              drain_cnt <= 2'd0;
              timeout   <= limit_hit;
            end
          end
        end
        S_DRAIN: begin
          // Two cycles let the tape finish the final write and move before it is parked.
          if (drain_cnt == 2'd1) begin
            fsm        <= S_HALTED;
            tape_reset <= 1'b1;
            running    <= 1'b0;
            halted     <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: begin
          fsm <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm_control.sv
// Bench for tm_control: reset state, per-cycle vector table, and BB2 runs against a 3-phase tape model.
// Latency: checks outputs one cycle after each consumed read and stability through the move phase.
// Backpressure: the tape model paces sym_valid one cycle in three and parks on tape_reset.
module tb_tm_control;

  logic        clock;
  logic        reset;
  logic        start;
  logic        tbl_we;
  logic [6:0]  tbl_addr;
  logic [7:0]  tbl_data;
  logic [2:0]  sym;
  logic        sym_valid;
  logic [2:0]  new_sym;
  logic        direction;
  logic        tape_reset;
  logic [3:0]  cur_state;
  logic        running;
  logic        halted;
  logic [31:0] steps;
  logic        timeout;

  tm_control #(
    .STATE_W(4), .SYM_W(3), .START_STATE(1), .HALT_STATE(0), .MAX_STEPS(4)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .tbl_we(tbl_we),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .sym(sym), .sym_valid(sym_valid),
    .new_sym(new_sym), .direction(direction), .tape_reset(tape_reset),
    .cur_state(cur_state), .running(running), .halted(halted),
    .steps(steps), .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] tape [512];
  logic [7:0] mtbl [128];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tape_reset"}, tape_reset, 1);
    chk({tag, "_running"},    running,    0);
    chk({tag, "_halted"},     halted,     0);
    chk({tag, "_steps"},      steps,      0);
    chk({tag, "_cur_state"},  cur_state,  1);
    chk({tag, "_new_sym"},    new_sym,    0);
    chk({tag, "_direction"},  direction,  0);
    chk({tag, "_timeout"},    timeout,    0);
  endtask

  task automatic write_entry(input logic [6:0] a, input logic [7:0] d);
    @(negedge clock);
    tbl_we = 1'b1; tbl_addr = a; tbl_data = d;
    @(negedge clock);
    tbl_we = 1'b0;
  endtask

  // BB2 run on a blank tape; optional illegal table write during RUN and optional reset at a given step.
  task automatic run_bb2(input int abort_at, input int poke_at);
    logic [7:0] e;
    logic [3:0] mst;
    int ph, head, msteps, cyc;
    bit done;
    for (int c = 0; c < 512; c++) tape[c] = 3'd0;
    head = 332; ph = 0; mst = 4'd1; msteps = 0; cyc = 0; done = 0; e = '0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    while (!done) begin
      sym_valid = 1'b0;
      tbl_we = 1'b0;
      if (tape_reset) begin
        done = 1;
      end else begin
        case (ph)
          0: begin
            chk("rd_steps_before", steps, msteps);
            sym = tape[head];
            sym_valid = 1'b1;
            e = mtbl[{mst, tape[head]}];
            mst = e[7:4];
            msteps++;
            if (msteps == poke_at) begin
              tbl_we = 1'b1; tbl_addr = 7'd8; tbl_data = 8'h0B;
            end
          end
          1: begin
            chk("wr_new_sym", new_sym, e[3:1]);
            chk("wr_dir", direction, e[0]);
            chk("wr_state", cur_state, mst);
            chk("wr_steps", steps, msteps);
            tape[head] = new_sym;
            if (msteps == abort_at) begin
              reset = 1'b0;
              @(negedge clock);
              reset = 1'b1;
              done = 1;
            end
          end
          default: begin
            chk("mv_new_sym", new_sym, e[3:1]);
            chk("mv_dir", direction, e[0]);
            chk("mv_running", running, 1);
            head = direction ? head + 1 : head - 1;
          end
        endcase
        ph = (ph == 2) ? 0 : ph + 1;
      end
      if (!done) begin
        @(negedge clock);
        cyc++;
        if (cyc > 300) begin
          n_cmp++; n_bad++;
          $display("FAIL run_budget: actual=%0d cycles required=halt within 300", cyc);
          done = 1;
        end
      end
    end
    if (abort_at == 0) chk("halt_at_read_phase", ph, 0);
  endtask

  task automatic check_bb2_result(input string tag);
`ifdef STEP_LIMIT_EN
    chk({tag, "_steps"}, steps, 4);
    chk({tag, "_cur_state"}, cur_state, 1);
    chk({tag, "_timeout"}, timeout, 1);
    chk({tag, "_cell330"}, tape[330], 0);
    for (int c = 331; c <= 333; c++) chk($sformatf("%s_cell%0d", tag, c), tape[c], 1);
`else
    chk({tag, "_steps"}, steps, 6);
    chk({tag, "_cur_state"}, cur_state, 0);
    chk({tag, "_timeout"}, timeout, 0);
    for (int c = 330; c <= 333; c++) chk($sformatf("%s_cell%0d", tag, c), tape[c], 1);
`endif
    chk({tag, "_halted"}, halted, 1);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_tape_reset"}, tape_reset, 1);
  endtask

  typedef struct {
    logic        st;
    logic        sv;
    logic [2:0]  sy;
    logic [3:0]  cs;
    logic [2:0]  ns;
    logic        dr;
    logic        run;
    logic        hlt;
    logic        trst;
    logic        chk_out;
    logic [31:0] stp;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    sym = '0; sym_valid = 1'b0;
    for (int i = 0; i < 128; i++) mtbl[i] = 8'h00;
    mtbl[8] = 8'h23; mtbl[9] = 8'h22; mtbl[16] = 8'h12; mtbl[17] = 8'h03;

    //            st    sv    sy    cs    ns    dr    run   hlt   trst  chk   steps
    vt[0]  = '{1'b1, 1'b1, 3'd0, 4'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0};
    vt[1]  = '{1'b0, 1'b1, 3'd0, 4'd2, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1};
    vt[2]  = '{1'b0, 1'b0, 3'd0, 4'd2, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1};
    vt[3]  = '{1'b1, 1'b0, 3'd0, 4'd2, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1};
    vt[4]  = '{1'b0, 1'b1, 3'd1, 4'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2};
    vt[5]  = '{1'b0, 1'b1, 3'd0, 4'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2};
    vt[6]  = '{1'b0, 1'b0, 3'd0, 4'd0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd2};
    vt[7]  = '{1'b0, 1'b1, 3'd0, 4'd0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd2};
    vt[8]  = '{1'b1, 1'b0, 3'd0, 4'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    vt[9]  = '{1'b0, 1'b1, 3'd1, 4'd2, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1};
    vt[10] = '{1'b0, 1'b1, 3'd0, 4'd1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2};
    vt[11] = '{1'b0, 1'b1, 3'd0, 4'd2, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd3};

    // Reset state
    repeat (2) @(negedge clock);
    chk_idle("rst");
    reset = 1'b1;

    // Load BB2: A0->1RB, A1->1LB, B0->1LA, B1->1RH
    write_entry(7'd8,  8'h23);
    write_entry(7'd9,  8'h22);
    write_entry(7'd16, 8'h12);
    write_entry(7'd17, 8'h03);

    // Cycle-by-cycle vectors driven directly on sym/sym_valid
    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      start = vt[i].st; sym_valid = vt[i].sv; sym = vt[i].sy;
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_state", i),   cur_state,  vt[i].cs);
      chk($sformatf("v%0d_steps", i),   steps,      vt[i].stp);
      chk($sformatf("v%0d_running", i), running,    vt[i].run);
      chk($sformatf("v%0d_halted", i),  halted,     vt[i].hlt);
      chk($sformatf("v%0d_treset", i),  tape_reset, vt[i].trst);
      if (vt[i].chk_out) begin
        chk($sformatf("v%0d_new_sym", i), new_sym,   vt[i].ns);
        chk($sformatf("v%0d_dir", i),     direction, vt[i].dr);
      end
    end

    // Reset in the middle of a run
    @(negedge clock);
    start = 1'b0; sym_valid = 1'b0; reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk_idle("midrun_rst");

    // Table write coincident with start: the run must use the new A0 entry (write 5, right, halt)
    @(negedge clock);
    tbl_we = 1'b1; tbl_addr = 7'd8; tbl_data = 8'h0B; start = 1'b1; sym_valid = 1'b1; sym = 3'd0;
    @(posedge clock);
    #1;
    chk("co_steps_after_start", steps, 0);
    chk("co_state_after_start", cur_state, 1);
    @(negedge clock);
    tbl_we = 1'b0; start = 1'b0; sym_valid = 1'b1; sym = 3'd0;
    @(posedge clock);
    #1;
    chk("co_state", cur_state, 0);
    chk("co_new_sym", new_sym, 5);
    chk("co_dir", direction, 1);
    chk("co_steps", steps, 1);
    @(negedge clock);
    sym_valid = 1'b0;
    @(negedge clock);
    chk("co_drain2_running", running, 1);
    chk("co_drain2_treset", tape_reset, 0);
    @(negedge clock);
    chk("co_halted", halted, 1);
    chk("co_treset", tape_reset, 1);
    write_entry(7'd8, 8'h23);

    // BB2 on the tape model, with a conflicting write attempted during RUN
    run_bb2(0, 2);
    check_bb2_result("bb2_poke");

    // Reset at step 3, then a clean restart on a fresh tape
    run_bb2(3, 0);
    chk_idle("abort");
    run_bb2(0, 0);
    check_bb2_result("bb2_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
